result_packer: RTL and testbench
================================

# result_packer

Drains the result FIFO, which the DUT writeback stage fills with one RTF_WIDTH-bit result per test vector, and serialises each result into a byte-stream frame for the host link. Each frame is one 8-bit sequence byte followed by the result bytes, MSB first. A valid/ready handshake connects the block to the host transmitter. The block also keeps a saturating frame counter for status readback.

## Interface
Parameters:
- RTF_WIDTH, 24, result width; must be a non-zero multiple of 8
- NBYTES, RTF_WIDTH/8, result bytes per frame (derived; do not override)
- CNT_WIDTH, 16, width of result_count

Ports:
- clock  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- rfifo_data  in  RTF_WIDTH  RES_FIFO read data; legacy (non-show-ahead) mode, valid the cycle after rfifo_rdreq
- rfifo_rdreq  out  1  RES_FIFO read request (combinational)
- rfifo_rdempty  in  1  RES_FIFO empty
- enable  in  1  permits starting a new frame
- seq_clear  in  1  clears the sequence number and result_count (acted on only in IDLE)
- byte_data  out  8  frame byte (registered)
- byte_valid  out  1  byte_data valid (registered)
- byte_ready  in  1  host accepts byte_data when byte_valid & byte_ready
- busy  out  1  high in any state other than IDLE
- result_count  out  CNT_WIDTH  completed frames, saturating

Decided: one clock (clock); reset is synchronous and active-high (reset).

## Operation
- State machine: IDLE, LATCH, SEND.
- **IDLE**
  - rfifo_rdreq = enable & ~rfifo_rdempty & ~seq_clear.
  - If rfifo_rdreq is high, go to LATCH.
  - If seq_clear is high: seq <= 0, result_count <= 0, and no read that cycle. seq_clear has priority over starting a frame.
- **LATCH**
  - Capture rfifo_data into shift register sh.
  - Load byte_data <= seq, byte_valid <= 1, byte index idx <= 0.
  - Go to SEND.
- **SEND** (byte_valid high throughout)
  - On byte_valid & byte_ready with idx < NBYTES:
    - byte_data <= sh[RTF_WIDTH-1 -: 8]
    - sh <= sh << 8
    - idx <= idx + 1
  - On acceptance with idx == NBYTES (last byte):
    - byte_valid <= 0
    - seq <= seq + 1, wrapping 255 -> 0
    - result_count <= result_count + 1, saturating at all-ones
    - go to IDLE
- Handshake rules:
  - byte_data is stable while byte_valid & ~byte_ready.
  - byte_valid never drops without acceptance, except on reset.
  - byte_ready is ignored when byte_valid is low.
- enable only gates frame start. Deasserting it mid-frame does not abort the frame.
- seq_clear outside IDLE is ignored; it is not latched.
- rfifo_rdreq is never asserted outside IDLE, so there is at most one outstanding FIFO read.
- busy = (state != IDLE).
- Reset behaviour:
  - Values: state IDLE, byte_valid 0, byte_data 0, seq 0, result_count 0, sh 0, idx 0, busy 0.
  - rfifo_rdreq is 0 because of enable/empty gating only when those inputs are inactive. The block never depends on rdreq during reset: the FSM is held in IDLE, and rfifo_rdreq is additionally forced low while reset is high.
  - Reset mid-frame drops the partially sent frame; the result already popped is lost.

## Timing
- Cycle T: IDLE, rfifo_rdreq high.
- T+1: LATCH; rfifo_data is sampled at the end of T+1.
- T+2: byte_valid high with the sequence byte.
- With byte_ready held high, bytes are presented on T+2 .. T+2+NBYTES, one per cycle with no bubbles.
- Last acceptance on T+2+NBYTES; IDLE on T+3+NBYTES.
- The next rfifo_rdreq can come no earlier than T+3+NBYTES, giving NBYTES+3 cycles per frame; 6 cycles at the default.
- Each low cycle of byte_ready adds exactly one cycle.
- result_count and seq update on the edge that accepts the last byte, so they are visible in the first IDLE cycle.

## Test plan
- Reset, then one FIFO entry 0xA1B2C3, enable=1, byte_ready=1:
  - rdreq for exactly 1 cycle
  - byte stream 0x00, 0xA1, 0xB2, 0xC3 on 4 consecutive cycles starting 2 cycles after rdreq
  - result_count=1, busy low afterwards
- Back-to-back: 3 entries, byte_ready=1:
  - sequence bytes 0x00, 0x01, 0x02
  - frames start 6 cycles apart
  - rdreq never asserted while busy
- Backpressure: byte_ready toggles 1,0,0,1,... during a frame:
  - byte_data is unchanged while stalled
  - no byte is duplicated or lost
  - frame length in cycles = 6 + number of stall cycles
- Sequence wrap and saturation:
  - Push 257 results: the 257th frame carries seq 0x00.
  - With CNT_WIDTH=4, result_count holds at 15.
- seq_clear and enable:
  - seq_clear pulsed mid-frame: no effect.
  - seq_clear pulsed in IDLE with FIFO non-empty: no rdreq that cycle; the next frame has seq 0x00 and result_count restarts from 1.
  - enable dropped mid-frame: the frame completes and no new rdreq follows.
- Reset mid-frame after the second byte:
  - byte_valid=0 and all outputs at reset values on the next cycle
  - the next frame starts with seq 0x00

Source files
------------

// File: rtl/result_packer.sv
// Drains the result FIFO and serialises each result as a byte frame:
// one sequence byte, then the result bytes MSB first, over valid/ready.
module result_packer #(
    parameter int RTF_WIDTH = 24,
    parameter int NBYTES    = RTF_WIDTH / 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [RTF_WIDTH-1:0] rfifo_data,
    output logic                 rfifo_rdreq,
    input  logic                 rfifo_rdempty,
    input  logic                 enable,
    input  logic                 seq_clear,
    output logic [7:0]           byte_data,
    output logic                 byte_valid,
    input  logic                 byte_ready,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] result_count
);
    localparam int IDX_W = $clog2(NBYTES + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES);

    typedef enum logic [1:0] {
        IDLE,
        LATCH,
        SEND
    } state_t;

    state_t                state_reg, state_next;
    logic [7:0]            seq_reg, seq_next;
    logic [CNT_WIDTH-1:0]  count_reg, count_next;
    logic [RTF_WIDTH-1:0]  sh_reg, sh_next;
    logic [IDX_W-1:0]      idx_reg, idx_next;
    logic [7:0]            data_reg, data_next;
    logic                  valid_reg, valid_next;
    logic                  rdreq_next;
    logic [RTF_WIDTH-1:0]  sh_shifted;

    // Byte-lane shift keeps the one-byte-result case free of empty part-selects.
    for (genvar gi = 0; gi < NBYTES; gi++) begin : g_shift
        if (gi == 0) begin : g_low
            assign sh_shifted[7:0] = 8'h00;
        end else begin : g_up
            assign sh_shifted[gi*8 +: 8] = sh_reg[(gi-1)*8 +: 8];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= IDLE;
            seq_reg   <= '0;
            count_reg <= '0;
            sh_reg    <= '0;
            idx_reg   <= '0;
            data_reg  <= '0;
            valid_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            seq_reg   <= seq_next;
            count_reg <= count_next;
            sh_reg    <= sh_next;
            idx_reg   <= idx_next;
            data_reg  <= data_next;
            valid_reg <= valid_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        seq_next   = seq_reg;
        count_next = count_reg;
        sh_next    = sh_reg;
        idx_next   = idx_reg;
        data_next  = data_reg;
        valid_next = valid_reg;
        rdreq_next = 1'b0;

        case (state_reg)
            IDLE: begin
                // Clearing wins over starting a frame in the same cycle.
                if (seq_clear) begin
                    seq_next   = '0;
                    count_next = '0;
                end else if (enable && !rfifo_rdempty) begin
                    rdreq_next = 1'b1;
                    state_next = LATCH;
                end
            end
            LATCH: begin
                sh_next    = rfifo_data;
                data_next  = seq_reg;
                valid_next = 1'b1;
                idx_next   = '0;
                state_next = SEND;
            end
            SEND: begin
                if (valid_reg && byte_ready) begin
                    if (idx_reg == LAST_IDX) begin
                        valid_next = 1'b0;
                        seq_next   = seq_reg + 8'd1;
                        if (count_reg != '1) begin
                            count_next = count_reg + 1'b1;
                        end
                        state_next = IDLE;
                    end else begin
                        data_next = sh_reg[RTF_WIDTH-1 -: 8];
                        sh_next   = sh_shifted;
                        idx_next  = idx_reg + 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign rfifo_rdreq  = rdreq_next & ~reset;
    assign byte_data    = data_reg;
    assign byte_valid   = valid_reg;
    assign busy         = (state_reg != IDLE);
    assign result_count = count_reg;

endmodule

// File: tb/tb_result_packer.sv
// Scoreboard bench for result_packer: a legacy-mode FIFO model feeds the DUT,
// expected frame bytes are queued at stimulus time and popped on acceptance.
module tb_result_packer;
    localparam int RTF_WIDTH = 24;
    localparam int NBYTES    = RTF_WIDTH / 8;
    localparam int CNT_WIDTH = 4;
    localparam int FRAME_CYC = NBYTES + 3;

    logic                 clock = 1'b0;
    logic                 reset = 1'b1;
    logic [RTF_WIDTH-1:0] rfifo_data = '0;
    logic                 rfifo_rdreq;
    logic                 rfifo_rdempty;
    logic                 enable = 1'b0;
    logic                 seq_clear = 1'b0;
    logic [7:0]           byte_data;
    logic                 byte_valid;
    logic                 byte_ready = 1'b1;
    logic                 busy;
    logic [CNT_WIDTH-1:0] result_count;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clock = ~clock;

    result_packer #(
        .RTF_WIDTH(RTF_WIDTH),
        .CNT_WIDTH(CNT_WIDTH)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .rfifo_data   (rfifo_data),
        .rfifo_rdreq  (rfifo_rdreq),
        .rfifo_rdempty(rfifo_rdempty),
        .enable       (enable),
        .seq_clear    (seq_clear),
        .byte_data    (byte_data),
        .byte_valid   (byte_valid),
        .byte_ready   (byte_ready),
        .busy         (busy),
        .result_count (result_count)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // FIFO model: read data appears the cycle after the request edge
    logic [RTF_WIDTH-1:0] fifo_mem [0:1023];
    int   wr_ptr = 0;
    int   rd_ptr = 0;
    logic rd_pending = 1'b0;
    assign rfifo_rdempty = (wr_ptr == rd_ptr);

    always begin
        @(negedge clock);
        rd_pending = rfifo_rdreq;
        @(posedge clock);
        #1;
        if (rd_pending) begin
            rfifo_data = fifo_mem[rd_ptr % 1024];
            rd_ptr = rd_ptr + 1;
        end
    end

    // Scoreboard and reference sequence/count model
    logic [7:0]           exp_q[$];
    logic [7:0]           exp_seq = 8'h00;
    logic [CNT_WIDTH-1:0] exp_cnt = '0;

    task automatic push_fifo(input logic [RTF_WIDTH-1:0] d);
        fifo_mem[wr_ptr % 1024] = d;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic expect_frame(input logic [RTF_WIDTH-1:0] d);
        exp_q.push_back(exp_seq);
        for (int i = 0; i < NBYTES; i++) begin
            exp_q.push_back(d[RTF_WIDTH-1-8*i -: 8]);
        end
        exp_seq = exp_seq + 8'd1;
        if (exp_cnt != '1) exp_cnt = exp_cnt + 1'b1;
    endtask

    // Output monitor, sampled on the falling edge
    int         cyc = 0;
    int         pos = 0;
    int         stall_total = 0;
    int         rdreq_total = 0;
    int         frames_done = 0;
    int         rd_cyc[$];
    int         start_cyc[$];
    int         end_cyc[$];
    logic [7:0] seq_log[$];
    logic [7:0] cur_seq = 8'h00;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;

    always @(negedge clock) begin
        cyc++;
        if (reset) begin
            pos = 0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check_eq("stall_valid", 32'(byte_valid), 32'd1);
                check_eq("stall_data", 32'(byte_data), 32'(prev_data));
            end
            if (rfifo_rdreq) begin
                rdreq_total++;
                rd_cyc.push_back(cyc);
                check_eq("rdreq_idle", 32'(busy), 32'd0);
            end
            if (byte_valid && byte_ready) begin
                if (pos == 0) begin
                    start_cyc.push_back(cyc);
                    seq_log.push_back(byte_data);
                    cur_seq = byte_data;
                end
                check_eq("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    check_eq("frame_byte", 32'(byte_data), 32'(exp_q.pop_front()));
                end
                if (pos == NBYTES) begin
                    end_cyc.push_back(cyc);
                    frames_done++;
                    pos = 0;
                    $display("[TB] frame %0d seq=0x%02h done at cycle %0d", frames_done, cur_seq, cyc);
                end else begin
                    pos++;
                end
            end
            if (byte_valid && !byte_ready) stall_total++;
            prev_stall = byte_valid && !byte_ready;
            prev_data  = byte_data;
        end
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        exp_q.delete();
        exp_seq = 8'h00;
        exp_cnt = '0;
        reset = 1'b0;
    endtask

    task automatic wait_drain(input int max);
        int n = 0;
        while ((busy || !rfifo_rdempty || exp_q.size() != 0) && n < max) begin
            tick();
            n++;
        end
        check_eq("drain_timeout", 32'(n < max), 32'd1);
    endtask

    task automatic wait_busy(input int max);
        int n = 0;
        while (!busy && n < max) begin
            tick();
            n++;
        end
        check_eq("busy_timeout", 32'(busy), 32'd1);
    endtask

    logic rdy_pat [0:11] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

    initial begin
        int base_rd, base_st, base_end, base_rdq, base_seq, n;

        // Single frame out of reset; rdreq held low while reset is high
        enable = 1'b1;
        byte_ready = 1'b1;
        push_fifo(24'hA1B2C3);
        tick();
        tick();
        check_eq("rst_rdreq", 32'(rfifo_rdreq), 32'd0);
        check_eq("rst_valid", 32'(byte_valid), 32'd0);
        check_eq("rst_data", 32'(byte_data), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_count", 32'(result_count), 32'd0);
        base_rd  = rdreq_total;
        base_rdq = rd_cyc.size();
        base_end = end_cyc.size();
        reset = 1'b0;
        expect_frame(24'hA1B2C3);
        wait_drain(50);
        check_eq("t1_rdreq_cnt", rdreq_total - base_rd, 1);
        check_eq("t1_latency", start_cyc[base_end] - rd_cyc[base_rdq], 2);
        check_eq("t1_burst", end_cyc[base_end] - start_cyc[base_end], NBYTES);
        check_eq("t1_count", 32'(result_count), 32'd1);
        check_eq("t1_busy", 32'(busy), 32'd0);

        // Back-to-back frames
        do_reset();
        base_end = start_cyc.size();
        base_rd  = rdreq_total;
        for (int i = 0; i < 3; i++) begin
            push_fifo(RTF_WIDTH'(32'h111111 * (i + 1)));
            expect_frame(RTF_WIDTH'(32'h111111 * (i + 1)));
        end
        wait_drain(100);
        check_eq("b2b_gap1", start_cyc[base_end+1] - start_cyc[base_end], FRAME_CYC);
        check_eq("b2b_gap2", start_cyc[base_end+2] - start_cyc[base_end+1], FRAME_CYC);
        check_eq("b2b_seq2", 32'(seq_log[base_end+2]), 32'h02);
        check_eq("b2b_rdreq", rdreq_total - base_rd, 3);
        check_eq("b2b_count", 32'(result_count), 32'd3);

        // Backpressure
        base_end = end_cyc.size();
        base_rdq = rd_cyc.size();
        base_st  = stall_total;
        push_fifo(24'h5A6B7C);
        expect_frame(24'h5A6B7C);
        for (int i = 0; i < 40 && end_cyc.size() == base_end; i++) begin
            byte_ready = rdy_pat[i % 12];
            tick();
        end
        byte_ready = 1'b1;
        wait_drain(20);
        check_eq("bp_stalled", 32'(stall_total > base_st), 32'd1);
        check_eq("bp_len", end_cyc[base_end] - rd_cyc[base_rdq] + 1, FRAME_CYC + (stall_total - base_st));

        // Sequence wrap and count saturation
        do_reset();
        base_seq = seq_log.size();
        for (int i = 0; i < 257; i++) begin
            logic [RTF_WIDTH-1:0] d;
            d = RTF_WIDTH'($urandom);
            push_fifo(d);
            expect_frame(d);
        end
        wait_drain(2500);
        check_eq("wrap_seq255", 32'(seq_log[base_seq+255]), 32'hFF);
        check_eq("wrap_seq256", 32'(seq_log[base_seq+256]), 32'h00);
        check_eq("sat_count", 32'(result_count), 32'd15);

        // seq_clear mid-frame is ignored
        base_seq = seq_log.size();
        push_fifo(24'h0BADF0);
        push_fifo(24'h1CEB00);
        expect_frame(24'h0BADF0);
        expect_frame(24'h1CEB00);
        wait_busy(10);
        tick();
        seq_clear = 1'b1;
        tick();
        seq_clear = 1'b0;
        wait_drain(50);
        check_eq("midclr_seq", 32'(seq_log[base_seq+1]), 32'h02);

        // seq_clear in IDLE with FIFO non-empty
        enable = 1'b0;
        base_rd = rdreq_total;
        push_fifo(24'hC0FFEE);
        tick();
        seq_clear = 1'b1;
        enable = 1'b1;
        #1;
        check_eq("clr_no_rdreq", 32'(rfifo_rdreq), 32'd0);
        tick();
        seq_clear = 1'b0;
        exp_seq = 8'h00;
        exp_cnt = '0;
        expect_frame(24'hC0FFEE);
        wait_drain(50);
        check_eq("clr_rdreq_cnt", rdreq_total - base_rd, 1);
        check_eq("clr_count", 32'(result_count), 32'd1);

        // enable dropped mid-frame
        base_rd  = rdreq_total;
        base_end = end_cyc.size();
        push_fifo(24'h123456);
        push_fifo(24'h789ABC);
        expect_frame(24'h123456);
        expect_frame(24'h789ABC);
        wait_busy(10);
        enable = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        check_eq("en_rdreq_cnt", rdreq_total - base_rd, 1);
        check_eq("en_frames", end_cyc.size() - base_end, 1);
        check_eq("en_busy", 32'(busy), 32'd0);
        check_eq("en_fifo_left", 32'(rfifo_rdempty), 32'd0);
        enable = 1'b1;
        wait_drain(50);
        check_eq("en_count", 32'(result_count), 32'd3);

        // Reset after the second byte of a frame
        push_fifo(24'hDEAD01);
        expect_frame(24'hDEAD01);
        n = 0;
        while (pos < 2 && n < 20) begin
            tick();
            n++;
        end
        check_eq("mid_pos_timeout", 32'(n < 20), 32'd1);
        reset = 1'b1;
        tick();
        check_eq("mrst_valid", 32'(byte_valid), 32'd0);
        check_eq("mrst_data", 32'(byte_data), 32'd0);
        check_eq("mrst_busy", 32'(busy), 32'd0);
        check_eq("mrst_count", 32'(result_count), 32'd0);
        check_eq("mrst_rdreq", 32'(rfifo_rdreq), 32'd0);
        exp_q.delete();
        exp_seq = 8'h00;
        exp_cnt = '0;
        reset = 1'b0;
        base_seq = seq_log.size();
        push_fifo(24'hBEEF02);
        expect_frame(24'hBEEF02);
        wait_drain(50);
        check_eq("mrst_seq", 32'(seq_log[base_seq]), 32'h00);
        check_eq("mrst_count1", 32'(result_count), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
